// File: rtl/carbon_sys_init_seq.sv
// Table-driven boot sequencer: holds the CPU halted, replays a compile-time list of CSR writes
// to a set of CSR masters with retry/timeout handling, then releases the core with one run pulse.
module carbon_sys_init_seq #(
    parameter int                        NUM_TGT       = 2,
    parameter int                        N_ENTRIES     = 6,
    parameter logic [N_ENTRIES*72-1:0]   INIT_TABLE    = '0,
    parameter int                        MAX_RETRY     = 1,
    parameter int                        TIMEOUT_CYC   = 256,
    parameter bit                        STOP_ON_FAULT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    output logic [NUM_TGT-1:0] csr_start,
    output logic [31:0]        csr_addr,
    output logic [31:0]        csr_wdata,
    input  logic [NUM_TGT-1:0] csr_busy,
    input  logic [NUM_TGT-1:0] csr_done,
    input  logic [NUM_TGT-1:0] csr_fault,
    output logic               halt_req,
    output logic               run_pulse,
    output logic               init_done,
    output logic               init_fault,
    output logic [7:0]         fault_index
);

    localparam int IW = $clog2(N_ENTRIES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IW-1:0] IDX_LAST  = IW'(N_ENTRIES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT   = TW'(TIMEOUT_CYC);

    localparam logic [2:0] ST_ISSUE   = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    logic [2:0]         state_q,       state_d;
    logic [IW-1:0]      idx_q,         idx_d;
    logic [RW-1:0]      retry_q,       retry_d;
    logic [TW-1:0]      tmo_q,         tmo_d;
    logic [NUM_TGT-1:0] csr_start_q,   csr_start_d;
    logic               halt_req_q,    halt_req_d;
    logic               run_pulse_q,   run_pulse_d;
    logic               init_done_q,   init_done_d;
    logic               init_fault_q,  init_fault_d;
    logic [7:0]         fault_index_q, fault_index_d;

    logic [71:0]        entry_tab [N_ENTRIES];
    logic [71:0]        cur_entry;
    logic [7:0]         cur_tgt;
    logic [NUM_TGT-1:0] tgt_hot;
    logic               tgt_valid;
    logic               busy_sel;
    logic               done_sel;
    logic               fault_sel;
    logic               fail;
    logic               unrec;
    logic               advance;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_tab
        assign entry_tab[g] = INIT_TABLE[g*72 +: 72];
    end

    // Address/data come straight from the table slot, so they stay put while idx_q is unchanged.
    assign cur_entry = entry_tab[idx_q];
    assign cur_tgt   = cur_entry[71:64];
    assign csr_addr  = cur_entry[63:32];
    assign csr_wdata = cur_entry[31:0];

    always_comb begin
        tgt_hot = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            tgt_hot[t] = (cur_tgt == 8'(t));
        end
    end

    // An out-of-range target decodes to no select bit at all.
    assign tgt_valid = |tgt_hot;
    assign busy_sel  = |(csr_busy & tgt_hot);
    assign done_sel  = |(csr_done & tgt_hot);
    assign fault_sel = |(csr_done & csr_fault & tgt_hot);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        tmo_d         = tmo_q;
        csr_start_d   = '0;
        halt_req_d    = halt_req_q;
        run_pulse_d   = 1'b0;
        init_done_d   = init_done_q;
        init_fault_d  = init_fault_q;
        fault_index_d = fault_index_q;
        fail          = 1'b0;
        unrec         = 1'b0;
        advance       = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                if (!tgt_valid) begin
                    unrec = 1'b1;
                end else if (!busy_sel) begin
                    csr_start_d = tgt_hot;
                    tmo_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the expiry cycle wins over the timeout.
                if (done_sel) begin
                    if (fault_sel) begin
                        fail = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fail = 1'b1;
                end else if (tmo_q != TMO_SAT) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (restart) begin
                    halt_req_d    = 1'b1;
                    init_done_d   = 1'b0;
                    init_fault_d  = 1'b0;
                    fault_index_d = '0;
                    idx_d         = '0;
                    retry_d       = '0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_HALTED: begin
                halt_req_d = 1'b1;
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase

        if (fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_ISSUE;
            end else begin
                unrec = 1'b1;
            end
        end

        // Only the first unrecoverable entry of a run is recorded.
        if (unrec) begin
            init_fault_d = 1'b1;
            if (!init_fault_q) begin
                fault_index_d = 8'(idx_q);
            end
            if (STOP_ON_FAULT) begin
                state_d = ST_HALTED;
            end else begin
                advance = 1'b1;
            end
        end

        // Release outputs are registered on entry to RELEASE so they line up with that cycle.
        if (advance) begin
            if (idx_q == IDX_LAST) begin
                state_d     = ST_RELEASE;
                halt_req_d  = 1'b0;
                run_pulse_d = 1'b1;
                init_done_d = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                retry_d = '0;
                state_d = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ISSUE;
            idx_q         <= '0;
            retry_q       <= '0;
            tmo_q         <= '0;
            csr_start_q   <= '0;
            halt_req_q    <= 1'b1;
            run_pulse_q   <= 1'b0;
            init_done_q   <= 1'b0;
            init_fault_q  <= 1'b0;
            fault_index_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            tmo_q         <= tmo_d;
            csr_start_q   <= csr_start_d;
            halt_req_q    <= halt_req_d;
            run_pulse_q   <= run_pulse_d;
            init_done_q   <= init_done_d;
            init_fault_q  <= init_fault_d;
            fault_index_q <= fault_index_d;
        end
    end

    assign csr_start   = csr_start_q;
    assign halt_req    = halt_req_q;
    assign run_pulse   = run_pulse_q;
    assign init_done   = init_done_q;
    assign init_fault  = init_fault_q;
    assign fault_index = fault_index_q;

endmodule

// File: tb/tb_carbon_sys_init_seq.sv
// Bench for carbon_sys_init_seq: two instances (halt-on-fault and continue-on-fault) driven by
// simple CSR target models; expected starts are queued up front and popped as starts appear.
module tb_carbon_sys_init_seq;

  localparam logic [71:0] A_E0 = {8'd0, 32'h0000_0100, 32'h0000_0001};
  localparam logic [71:0] A_E1 = {8'd1, 32'h0000_0200, 32'h0000_0005};
  localparam logic [71:0] A_E2 = {8'd1, 32'h0000_0204, 32'h0000_0500};
  localparam logic [3*72-1:0] A_TABLE = {A_E2, A_E1, A_E0};

  localparam logic [71:0] B_E0 = {8'd0, 32'h0000_0010, 32'h0000_000A};
  localparam logic [71:0] B_E1 = {8'd1, 32'h0000_0014, 32'h0000_000B};
  localparam logic [71:0] B_E2 = {8'd5, 32'h0000_0018, 32'h0000_000C};
  localparam logic [71:0] B_E3 = {8'd0, 32'h0000_001C, 32'h0000_000D};
  localparam logic [4*72-1:0] B_TABLE = {B_E3, B_E2, B_E1, B_E0};

  logic        clk = 1'b0;
  logic        rst_n_v   [2];
  logic        restart_v [2];
  logic [1:0]  start_v   [2];
  logic [31:0] addr_v    [2];
  logic [31:0] wdata_v   [2];
  logic [1:0]  busy_v    [2];
  logic [1:0]  done_v    [2];
  logic [1:0]  fault_v   [2];
  logic        halt_v    [2];
  logic        run_v     [2];
  logic        idone_v   [2];
  logic        ifault_v  [2];
  logic [7:0]  fidx_v    [2];

  logic [1:0]  mute_v    [2];
  logic [7:0]  fmask_v   [2][2];
  int          cnt_m     [2][2];
  int          iss_m     [2][2];
  logic        fpend_m   [2][2];

  int          checks = 0;
  int          failures = 0;
  logic [71:0] exp_q[$];
  int          start_smp[$];
  int          smp;
  int          run_cnt;
  int          run_smp;
  logic        prev_start;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  carbon_sys_init_seq #(
    .NUM_TGT(2), .N_ENTRIES(3), .INIT_TABLE(A_TABLE),
    .MAX_RETRY(1), .TIMEOUT_CYC(16), .STOP_ON_FAULT(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .restart(restart_v[0]),
    .csr_start(start_v[0]), .csr_addr(addr_v[0]), .csr_wdata(wdata_v[0]),
    .csr_busy(busy_v[0]), .csr_done(done_v[0]), .csr_fault(fault_v[0]),
    .halt_req(halt_v[0]), .run_pulse(run_v[0]), .init_done(idone_v[0]),
    .init_fault(ifault_v[0]), .fault_index(fidx_v[0])
  );

  carbon_sys_init_seq #(
    .NUM_TGT(2), .N_ENTRIES(4), .INIT_TABLE(B_TABLE),
    .MAX_RETRY(1), .TIMEOUT_CYC(16), .STOP_ON_FAULT(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .restart(restart_v[1]),
    .csr_start(start_v[1]), .csr_addr(addr_v[1]), .csr_wdata(wdata_v[1]),
    .csr_busy(busy_v[1]), .csr_done(done_v[1]), .csr_fault(fault_v[1]),
    .halt_req(halt_v[1]), .run_pulse(run_v[1]), .init_done(idone_v[1]),
    .init_fault(ifault_v[1]), .fault_index(fidx_v[1])
  );

  // Target model: done one cycle after the start cycle; fault taken from fmask by issue number.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 2; t++) begin
        done_v[d][t]  = 1'b0;
        fault_v[d][t] = 1'b0;
        if (!rst_n_v[d]) begin
          cnt_m[d][t] = 0;
          iss_m[d][t] = 0;
        end else begin
          if (cnt_m[d][t] > 0) begin
            cnt_m[d][t] = cnt_m[d][t] - 1;
            if (cnt_m[d][t] == 0) begin
              done_v[d][t]  = 1'b1;
              fault_v[d][t] = fpend_m[d][t];
            end
          end
          if (start_v[d][t] && !mute_v[d][t]) begin
            cnt_m[d][t]   = 1;
            fpend_m[d][t] = (iss_m[d][t] < 8) ? fmask_v[d][t][iss_m[d][t][2:0]] : 1'b0;
            iss_m[d][t]   = iss_m[d][t] + 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int d);
    rst_n_v[d]   = 1'b0;
    restart_v[d] = 1'b0;
    busy_v[d]    = 2'b00;
    exp_q.delete();
    start_smp.delete();
    run_cnt    = 0;
    run_smp    = -1;
    prev_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_rst(input int d);
    rst_n_v[d] = 1'b1;
    smp = 0;
  endtask

  // Advance n cycles, sampling mid-cycle; each start is scored against the expected queue.
  task automatic step(input int d, input int n);
    logic [7:0]  obs_tgt;
    logic [71:0] obs;
    logic [71:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      smp++;
      if (start_v[d] !== 2'b00) begin
        obs_tgt = (start_v[d] === 2'b01) ? 8'd0 : (start_v[d] === 2'b10) ? 8'd1 : 8'hFF;
        obs = {obs_tgt, addr_v[d], wdata_v[d]};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL start_unexpected dut%0d: got %h at sample %0d, none expected", d, obs, smp);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            failures++;
            $display("FAIL start_entry dut%0d: got %h expected %h at sample %0d", d, obs, exp, smp);
          end
        end
        checks++;
        if (prev_start !== 1'b0) begin
          failures++;
          $display("FAIL start_back_to_back dut%0d: start at samples %0d and %0d", d, smp - 1, smp);
        end
        start_smp.push_back(smp);
      end
      prev_start = (start_v[d] !== 2'b00);
      if (run_v[d] === 1'b1) begin
        run_cnt++;
        run_smp = smp;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(0);
    checks++; if (halt_v[0] !== 1'b1) begin failures++; $display("FAIL reset_halt: got %b expected 1", halt_v[0]); end
    checks++; if (run_v[0] !== 1'b0) begin failures++; $display("FAIL reset_run: got %b expected 0", run_v[0]); end
    checks++; if (idone_v[0] !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", idone_v[0]); end
    checks++; if (ifault_v[0] !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", ifault_v[0]); end
    checks++; if (fidx_v[0] !== 8'd0) begin failures++; $display("FAIL reset_fidx: got %0d expected 0", fidx_v[0]); end
    checks++; if (start_v[0] !== 2'b00) begin failures++; $display("FAIL reset_start: got %b expected 00", start_v[0]); end
  endtask

  task automatic test_success();
    do_reset(0);
    exp_q.push_back(A_E0); exp_q.push_back(A_E1); exp_q.push_back(A_E2);
    release_rst(0);
    step(0, 14);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL success_pending: got %0d left expected 0", exp_q.size()); end
    checks++;
    if (start_smp.size() != 3) begin
      failures++; $display("FAIL success_nstart: got %0d expected 3", start_smp.size());
    end else if (start_smp[0] != 1 || start_smp[1] != 4 || start_smp[2] != 7) begin
      failures++; $display("FAIL success_start_time: got %0d,%0d,%0d expected 1,4,7", start_smp[0], start_smp[1], start_smp[2]);
    end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL success_run_cnt: got %0d expected 1", run_cnt); end
    checks++; if (run_smp != 9) begin failures++; $display("FAIL success_run_time: got %0d expected 9", run_smp); end
    checks++; if (halt_v[0] !== 1'b0) begin failures++; $display("FAIL success_halt: got %b expected 0", halt_v[0]); end
    checks++; if (idone_v[0] !== 1'b1) begin failures++; $display("FAIL success_done: got %b expected 1", idone_v[0]); end
    checks++; if (ifault_v[0] !== 1'b0) begin failures++; $display("FAIL success_fault: got %b expected 0", ifault_v[0]); end
  endtask

  task automatic test_restart();
    run_cnt = 0;
    start_smp.delete();
    exp_q.push_back(A_E0); exp_q.push_back(A_E1); exp_q.push_back(A_E2);
    restart_v[0] = 1'b1;
    step(0, 1);
    restart_v[0] = 1'b0;
    checks++; if (halt_v[0] !== 1'b1) begin failures++; $display("FAIL restart_halt: got %b expected 1", halt_v[0]); end
    checks++; if (idone_v[0] !== 1'b0) begin failures++; $display("FAIL restart_done_clr: got %b expected 0", idone_v[0]); end
    step(0, 14);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL restart_pending: got %0d left expected 0", exp_q.size()); end
    checks++; if (start_smp.size() != 3) begin failures++; $display("FAIL restart_nstart: got %0d expected 3", start_smp.size()); end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL restart_run_cnt: got %0d expected 1", run_cnt); end
    checks++; if (halt_v[0] !== 1'b0) begin failures++; $display("FAIL restart_release: got %b expected 0", halt_v[0]); end
  endtask

  task automatic test_restart_ignored();
    do_reset(0);
    exp_q.push_back(A_E0); exp_q.push_back(A_E1); exp_q.push_back(A_E2);
    release_rst(0);
    for (int i = 0; i < 14; i++) begin
      restart_v[0] = (smp == 1 || smp == 9);
      step(0, 1);
    end
    restart_v[0] = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_ign_pending: got %0d left expected 0", exp_q.size()); end
    checks++;
    if (start_smp.size() != 3) begin
      failures++; $display("FAIL rst_ign_nstart: got %0d expected 3", start_smp.size());
    end else if (start_smp[1] != 4 || start_smp[2] != 7) begin
      failures++; $display("FAIL rst_ign_start_time: got %0d,%0d expected 4,7", start_smp[1], start_smp[2]);
    end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL rst_ign_run_cnt: got %0d expected 1", run_cnt); end
    checks++; if (halt_v[0] !== 1'b0) begin failures++; $display("FAIL rst_ign_halt: got %b expected 0", halt_v[0]); end
    checks++; if (idone_v[0] !== 1'b1) begin failures++; $display("FAIL rst_ign_done: got %b expected 1", idone_v[0]); end
  endtask

  task automatic test_retry();
    do_reset(0);
    fmask_v[0][1] = 8'b0000_0001;
    exp_q.push_back(A_E0); exp_q.push_back(A_E1); exp_q.push_back(A_E1); exp_q.push_back(A_E2);
    release_rst(0);
    step(0, 20);
    fmask_v[0][1] = 8'h00;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL retry_pending: got %0d left expected 0", exp_q.size()); end
    checks++;
    if (start_smp.size() != 4) begin
      failures++; $display("FAIL retry_nstart: got %0d expected 4", start_smp.size());
    end else if (start_smp[2] != 7) begin
      failures++; $display("FAIL retry_reissue_time: got %0d expected 7", start_smp[2]);
    end
    checks++; if (run_smp != 12) begin failures++; $display("FAIL retry_run_time: got %0d expected 12", run_smp); end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL retry_run_cnt: got %0d expected 1", run_cnt); end
    checks++; if (ifault_v[0] !== 1'b0) begin failures++; $display("FAIL retry_fault: got %b expected 0", ifault_v[0]); end
    checks++; if (idone_v[0] !== 1'b1) begin failures++; $display("FAIL retry_done: got %b expected 1", idone_v[0]); end
  endtask

  task automatic test_busy();
    do_reset(0);
    busy_v[0] = 2'b10;
    exp_q.push_back(A_E0); exp_q.push_back(A_E1); exp_q.push_back(A_E2);
    release_rst(0);
    for (int i = 0; i < 20; i++) begin
      if (smp == 10) busy_v[0] = 2'b00;
      step(0, 1);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL busy_pending: got %0d left expected 0", exp_q.size()); end
    checks++;
    if (start_smp.size() != 3) begin
      failures++; $display("FAIL busy_nstart: got %0d expected 3", start_smp.size());
    end else if (start_smp[1] != 11) begin
      failures++; $display("FAIL busy_gate_time: got %0d expected 11", start_smp[1]);
    end
    checks++; if (run_smp != 16) begin failures++; $display("FAIL busy_run_time: got %0d expected 16", run_smp); end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL busy_run_cnt: got %0d expected 1", run_cnt); end
  endtask

  task automatic test_timeout();
    do_reset(0);
    mute_v[0] = 2'b01;
    exp_q.push_back(A_E0); exp_q.push_back(A_E0);
    release_rst(0);
    step(0, 45);
    checks++;
    if (start_smp.size() != 2) begin
      failures++; $display("FAIL timeout_nstart: got %0d expected 2", start_smp.size());
    end else if (start_smp[0] != 1 || start_smp[1] - start_smp[0] != 17) begin
      failures++; $display("FAIL timeout_spacing: got %0d,%0d expected 1,18", start_smp[0], start_smp[1]);
    end
    checks++; if (ifault_v[0] !== 1'b1) begin failures++; $display("FAIL timeout_fault: got %b expected 1", ifault_v[0]); end
    checks++; if (fidx_v[0] !== 8'd0) begin failures++; $display("FAIL timeout_fidx: got %0d expected 0", fidx_v[0]); end
    checks++; if (halt_v[0] !== 1'b1) begin failures++; $display("FAIL timeout_halt: got %b expected 1", halt_v[0]); end
    checks++; if (idone_v[0] !== 1'b0) begin failures++; $display("FAIL timeout_done: got %b expected 0", idone_v[0]); end
    restart_v[0] = 1'b1;
    step(0, 3);
    restart_v[0] = 1'b0;
    step(0, 5);
    checks++; if (start_smp.size() != 2) begin failures++; $display("FAIL halted_restart_start: got %0d starts expected 2", start_smp.size()); end
    checks++; if (halt_v[0] !== 1'b1) begin failures++; $display("FAIL halted_restart_halt: got %b expected 1", halt_v[0]); end
    checks++; if (ifault_v[0] !== 1'b1) begin failures++; $display("FAIL halted_restart_fault: got %b expected 1", ifault_v[0]); end
    checks++; if (run_cnt != 0) begin failures++; $display("FAIL timeout_run_cnt: got %0d expected 0", run_cnt); end
    mute_v[0] = 2'b00;
  endtask

  task automatic test_continue();
    do_reset(1);
    fmask_v[1][1] = 8'hFF;
    exp_q.push_back(B_E0); exp_q.push_back(B_E1); exp_q.push_back(B_E1); exp_q.push_back(B_E3);
    release_rst(1);
    step(1, 20);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cont_pending: got %0d left expected 0", exp_q.size()); end
    checks++;
    if (start_smp.size() != 4) begin
      failures++; $display("FAIL cont_nstart: got %0d expected 4", start_smp.size());
    end else if (start_smp[3] != 11) begin
      failures++; $display("FAIL cont_badtgt_time: got %0d expected 11", start_smp[3]);
    end
    checks++; if (run_smp != 13) begin failures++; $display("FAIL cont_run_time: got %0d expected 13", run_smp); end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL cont_run_cnt: got %0d expected 1", run_cnt); end
    checks++; if (ifault_v[1] !== 1'b1) begin failures++; $display("FAIL cont_fault: got %b expected 1", ifault_v[1]); end
    checks++; if (fidx_v[1] !== 8'd1) begin failures++; $display("FAIL cont_fidx: got %0d expected 1", fidx_v[1]); end
    checks++; if (halt_v[1] !== 1'b0) begin failures++; $display("FAIL cont_halt: got %b expected 0", halt_v[1]); end
    checks++; if (idone_v[1] !== 1'b1) begin failures++; $display("FAIL cont_done: got %b expected 1", idone_v[1]); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(1);
    exp_q.push_back(B_E0); exp_q.push_back(B_E1); exp_q.push_back(B_E1); exp_q.push_back(B_E3);
    release_rst(1);
    step(1, 11);
    checks++; if (start_v[1] !== 2'b01) begin failures++; $display("FAIL midwait_pre_start: got %b expected 01", start_v[1]); end
    checks++; if (ifault_v[1] !== 1'b1) begin failures++; $display("FAIL midwait_pre_fault: got %b expected 1", ifault_v[1]); end
    #2;
    rst_n_v[1] = 1'b0;
    #1;
    checks++; if (start_v[1] !== 2'b00) begin failures++; $display("FAIL midwait_start: got %b expected 00", start_v[1]); end
    checks++; if (halt_v[1] !== 1'b1) begin failures++; $display("FAIL midwait_halt: got %b expected 1", halt_v[1]); end
    checks++; if (ifault_v[1] !== 1'b0) begin failures++; $display("FAIL midwait_fault: got %b expected 0", ifault_v[1]); end
    checks++; if (fidx_v[1] !== 8'd0) begin failures++; $display("FAIL midwait_fidx: got %0d expected 0", fidx_v[1]); end
    checks++; if (idone_v[1] !== 1'b0 || run_v[1] !== 1'b0) begin failures++; $display("FAIL midwait_done_run: got %b%b expected 00", idone_v[1], run_v[1]); end
    do_reset(1);
    exp_q.push_back(B_E0); exp_q.push_back(B_E1); exp_q.push_back(B_E1); exp_q.push_back(B_E3);
    release_rst(1);
    step(1, 20);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midwait_replay_pending: got %0d left expected 0", exp_q.size()); end
    checks++; if (run_cnt != 1) begin failures++; $display("FAIL midwait_replay_run: got %0d expected 1", run_cnt); end
    checks++; if (fidx_v[1] !== 8'd1) begin failures++; $display("FAIL midwait_replay_fidx: got %0d expected 1", fidx_v[1]); end
    fmask_v[1][1] = 8'h00;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n_v[d]   = 1'b0;
      restart_v[d] = 1'b0;
      busy_v[d]    = 2'b00;
      mute_v[d]    = 2'b00;
      done_v[d]    = 2'b00;
      fault_v[d]   = 2'b00;
      for (int t = 0; t < 2; t++) begin
        fmask_v[d][t] = 8'h00;
        cnt_m[d][t]   = 0;
        iss_m[d][t]   = 0;
        fpend_m[d][t] = 1'b0;
      end
    end
    smp = 0;
    run_cnt = 0;
    run_smp = -1;
    prev_start = 1'b0;

    test_reset();
    test_success();
    test_restart();
    test_restart_ignored();
    test_retry();
    test_busy();
    test_timeout();
    test_continue();
    test_reset_mid_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
